soc_bus_fabric: RTL
===================

# soc_bus_fabric

Parametrised memory-mapped interconnect between the picorv32 native memory port and the SoC peripherals. It replaces the hard-wired page decode in the SoC top with a registered, handshaken fabric, which provides:
- NUM_SLAVES external slave ports, each with its own ready and read-data return;
- an internal GPIO/status register page;
- an unmapped-address error response;
- an optional bus timeout.

## Interface
- NUM_SLAVES, 2: number of external slave ports (1..8).
- SLAVE_PAGES, {8'hFF, 8'h00}: packed NUM_SLAVES×8 vector; slave i owns address page mem_addr[31:24] == SLAVE_PAGES[8i+:8].
- GPIO_PAGE, 8'hFE: page of the internal register block.
- GPIO_W, 6: GPIO output/input width (1..32).
- GPIO_RESET, 0: reset value of gpio_out.
- TIMEOUT_CYCLES, 1024: cycles in ACCESS before timeout (only with SOC_BUS_TIMEOUT_EN).
- clk  in  1  system clock.
- n_reset  in  1  asynchronous, active-low reset.
- mem_valid, mem_instr  in  1  CPU request; mem_instr is ignored by decode.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  CPU byte strobes; 0 = read.
- mem_ready  out  1  one-cycle response strobe.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- s_valid  out  NUM_SLAVES  one-hot request to the slaves.
- s_addr  out  24  registered mem_addr[23:0].
- s_wdata  out  32  registered write data.
- s_wstrb  out  4  registered strobes.
- s_ready  in  NUM_SLAVES  slave completion strobes.
- s_rdata  in  32×NUM_SLAVES  slave read data; slave i at [32i+:32].
- gpio_out  out  GPIO_W  output register.
- gpio_in  in  GPIO_W  asynchronous inputs.
- bus_error  out  1  sticky error flag.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On mem_valid=1, latch addr/wdata/wstrb and decode the page, then enter ACCESS.
  - Decode priority: slave match (lowest index wins on duplicate pages), then GPIO_PAGE, else unmapped.
- ACCESS, external slave:
  - s_valid[sel]=1 is held until s_ready[sel]=1.
  - s_rdata[sel] is captured, then the FSM enters RESP.
  - s_ready on non-selected slaves is ignored.
- ACCESS, GPIO page: completes in one cycle. The register is selected by addr[3:2]:
  - 0: gpio_out, RW, byte-lane writes via wstrb.
  - 1: gpio_in, RO, two-flop synchronised.
  - 2: status, bit0 = bus_error, bit1 = last error was a timeout; writing 1 to bit0 clears both bits.
  - 3: reads 0; writes are ignored.
  - Bits above GPIO_W read as 0.
- ACCESS, unmapped: completes in one cycle with rdata=0; sets bus_error; the write is dropped.
- RESP: mem_ready=1 for exactly one cycle with mem_rdata valid, then the FSM returns to IDLE. mem_valid sampled in RESP does not start a new access.
- mem_valid dropping in ACCESS is ignored: the transaction completes normally.
- If a write to status clears bus_error in the same cycle that an error is set, the set wins.
- Reset, including mid-transaction:
  - FSM returns to IDLE.
  - s_valid=0, mem_ready=0, mem_rdata=0, s_addr/s_wdata/s_wstrb=0.
  - gpio_out=GPIO_RESET, bus_error=0, synchroniser flops=0.
  - Any pending slave transaction is abandoned.

## Timing
- All outputs are registered.
- mem_valid rises at cycle 0:
  - s_valid rises at cycle 1.
  - s_ready observed at cycle k gives mem_ready at cycle k+1.
  - s_valid falls at cycle k+1.
- Minimum external latency: mem_ready at cycle 2, when s_ready is returned at cycle 1.
- GPIO or unmapped access: mem_ready at cycle 2.
- gpio_out updates at the same edge that raises mem_ready.
- gpio_in latency: two cycles to the synchroniser output.
- Back-to-back: the next mem_valid can be accepted in the cycle after RESP.

## Configuration
- SOC_BUS_TIMEOUT_EN defined:
  - A counter runs in ACCESS for external slaves.
  - On reaching TIMEOUT_CYCLES with no s_ready, s_valid drops and the FSM enters RESP with mem_rdata=32'hDEAD_BEEF.
  - bus_error and status bit1 are set.
  - The counter clears on entry to ACCESS.
- SOC_BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; status bit1 reads 0.

## Structure
- Package soc_bus_pkg holds:
  - typedef enum for the FSM states;
  - register offsets REG_GPIO_OUT, REG_GPIO_IN, REG_STATUS;
  - the timeout read value BUS_TIMEOUT_DATA;
  - page width constant PAGE_W=8.
- One sub-module: soc_gpio_regs, containing the GPIO/status registers and the input synchroniser. The fabric drives its write strobe and reads its data.

## Test plan
- Read of slave 0, address 0x0000_0010:
  - s_valid=2'b01 and s_addr=24'h10 at cycle 1.
  - Slave 0 returns s_ready with 32'h1234_5678 at cycle 3.
  - mem_ready at cycle 4 with rdata 32'h1234_5678.
- Write 0x41 (wstrb=4'b0001) to 0xFF00_0000: s_valid=2'b10, s_wdata=0x41, s_wstrb=1; s_valid is held until s_ready; one mem_ready pulse.
- GPIO:
  - Write 0x2A to 0xFE00_0000, then read it back: gpio_out=6'h2A; rdata=0x2A; mem_ready at cycle 2.
  - Drive gpio_in=6'h15 and read 0xFE00_0004: rdata=0x15.
- Unmapped:
  - Read of 0x8000_0000: rdata=0, bus_error=1.
  - Write 1 to 0xFE00_0008: bus_error=0.
- Timeout (SOC_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16), slave 0 never ready: mem_ready after 16 ACCESS cycles, rdata=32'hDEAD_BEEF, status reads 0x3.
- n_reset asserted during an ACCESS with s_valid high:
  - s_valid=0, gpio_out=GPIO_RESET, FSM in IDLE.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC memory-mapped bus fabric.
// Holds the FSM state and target encodings, register offsets and the timeout read value.
package soc_bus_pkg;

  localparam int PAGE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bus_state_t;

  typedef enum logic [1:0] {
    TGT_SLAVE,
    TGT_GPIO,
    TGT_NONE
  } bus_tgt_t;

  localparam logic [1:0] REG_GPIO_OUT = 2'd0;
  localparam logic [1:0] REG_GPIO_IN  = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;

  localparam logic [31:0] BUS_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_gpio_regs.sv
// GPIO output/input and sticky status registers; reads are combinational, writes land on the strobe edge.
// gpio_in passes through a two-flop synchroniser; no backpressure, every strobe is accepted.
module soc_gpio_regs
  import soc_bus_pkg::*;
#(
  parameter int                GPIO_W     = 6,
  parameter logic [GPIO_W-1:0] GPIO_RESET = '0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_wr_vld,
  input  logic [1:0]        i_reg_sel,
  input  logic [31:0]       i_wr_dat,
  input  logic [3:0]        i_wr_strb,
  input  logic              i_err_set,
  input  logic              i_tmo_set,
  input  logic [GPIO_W-1:0] i_gpio_in,
  output logic [31:0]       o_rd_dat,
  output logic [GPIO_W-1:0] o_gpio_out,
  output logic              o_bus_error
);

  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;
  logic              r_err;
  logic              r_tmo;
  logic              w_unused;

  assign w_unused = ^{i_wr_dat, i_wr_strb};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_gpio_out <= GPIO_RESET;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_err      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_sync1 <= i_gpio_in;
      r_sync2 <= r_sync1;
      if (i_wr_vld && i_reg_sel == REG_GPIO_OUT) begin
        for (int b = 0; b < GPIO_W; b++) begin
          if (i_wr_strb[b/8]) r_gpio_out[b] <= i_wr_dat[b];
        end
      end
      // A new error outranks a simultaneous clear.
      if (i_err_set) begin
        r_err <= 1'b1;
        r_tmo <= i_tmo_set;
      end else if (i_wr_vld && i_reg_sel == REG_STATUS && i_wr_strb[0] && i_wr_dat[0]) begin
        r_err <= 1'b0;
        r_tmo <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rd_dat = '0;
    case (i_reg_sel)
      REG_GPIO_OUT: o_rd_dat[GPIO_W-1:0] = r_gpio_out;
      REG_GPIO_IN:  o_rd_dat[GPIO_W-1:0] = r_sync2;
      REG_STATUS:   o_rd_dat[1:0]        = {r_tmo, r_err};
      default:      o_rd_dat             = '0;
    endcase
  end

  assign o_gpio_out  = r_gpio_out;
  assign o_bus_error = r_err;

endmodule

// File: rtl/soc_bus_fabric.sv
// picorv32 native-port fabric: slave/GPIO/unmapped decode, mem_ready at s_ready+1 (GPIO/unmapped: cycle 2).
// s_valid held until s_ready; SOC_BUS_TIMEOUT_EN adds an ACCESS timeout returning BUS_TIMEOUT_DATA.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                         NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*PAGE_W-1:0] SLAVE_PAGES  = {8'hFF, 8'h00},
  parameter logic [PAGE_W-1:0]          GPIO_PAGE      = 8'hFE,
  parameter int                         GPIO_W         = 6,
  parameter logic [GPIO_W-1:0]          GPIO_RESET     = '0,
  parameter int                         TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     mem_valid,
  input  logic                     mem_instr,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [23:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [GPIO_W-1:0]        gpio_out,
  input  logic [GPIO_W-1:0]        gpio_in,
  output logic                     bus_error
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  bus_state_t            r_state;
  bus_tgt_t              r_tgt;
  logic [SEL_W-1:0]      r_sel;
  logic [NUM_SLAVES-1:0] r_s_valid;
  logic [23:0]           r_s_addr;
  logic [31:0]           r_s_wdata;
  logic [3:0]            r_s_wstrb;
  logic                  r_mem_ready;
  logic [31:0]           r_mem_rdata;

  logic             w_hit;
  logic [SEL_W-1:0] w_sel;
  logic             w_tmo;
  logic             w_gpio_wr;
  logic             w_err_set;
  logic [31:0]      w_gpio_rd;
  logic             w_unused;

  assign w_unused = ^{mem_instr, 32'(TIMEOUT_CYCLES)};

  // Descending scan so the lowest matching index overrides any duplicate page.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (mem_addr[31 -: PAGE_W] == SLAVE_PAGES[i*PAGE_W +: PAGE_W]) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

`ifdef SOC_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_tmo_cnt <= '0;
    end else if (r_tgt == TGT_SLAVE) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_state == ST_ACCESS) && (r_tgt == TGT_SLAVE) && !s_ready[r_sel] &&
                 (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= ST_IDLE;
      r_tgt       <= TGT_NONE;
      r_sel       <= '0;
      r_s_valid   <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wstrb   <= '0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_valid) begin
            r_s_addr  <= mem_addr[23:0];
            r_s_wdata <= mem_wdata;
            r_s_wstrb <= mem_wstrb;
            r_sel     <= w_sel;
            if (w_hit) begin
              r_tgt     <= TGT_SLAVE;
              r_s_valid <= NUM_SLAVES'(1) << w_sel;
            end else if (mem_addr[31 -: PAGE_W] == GPIO_PAGE) begin
              r_tgt <= TGT_GPIO;
            end else begin
              r_tgt <= TGT_NONE;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          case (r_tgt)
            TGT_SLAVE: begin
              if (s_ready[r_sel]) begin
                r_s_valid   <= '0;
                r_mem_rdata <= s_rdata[r_sel*32 +: 32];
                r_mem_ready <= 1'b1;
                r_state     <= ST_RESP;
              end else if (w_tmo) begin
                r_s_valid   <= '0;
                r_mem_rdata <= BUS_TIMEOUT_DATA;
                r_mem_ready <= 1'b1;
                r_state     <= ST_RESP;
              end
            end
            TGT_GPIO: begin
              r_mem_rdata <= w_gpio_rd;
              r_mem_ready <= 1'b1;
              r_state     <= ST_RESP;
            end
            default: begin
              r_mem_rdata <= '0;
              r_mem_ready <= 1'b1;
              r_state     <= ST_RESP;
            end
          endcase
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_gpio_wr = (r_state == ST_ACCESS) && (r_tgt == TGT_GPIO) && (|r_s_wstrb);
  assign w_err_set = (r_state == ST_ACCESS) && ((r_tgt == TGT_NONE) || w_tmo);

  soc_gpio_regs #(
    .GPIO_W     (GPIO_W),
    .GPIO_RESET (GPIO_RESET)
  ) u_gpio_regs (
    .clk         (clk),
    .n_reset     (n_reset),
    .i_wr_vld    (w_gpio_wr),
    .i_reg_sel   (r_s_addr[3:2]),
    .i_wr_dat    (r_s_wdata),
    .i_wr_strb   (r_s_wstrb),
    .i_err_set   (w_err_set),
    .i_tmo_set   (w_tmo),
    .i_gpio_in   (gpio_in),
    .o_rd_dat    (w_gpio_rd),
    .o_gpio_out  (gpio_out),
    .o_bus_error (bus_error)
  );

  assign mem_ready = r_mem_ready;
  assign mem_rdata = r_mem_rdata;
  assign s_valid   = r_s_valid;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_wstrb   = r_s_wstrb;

endmodule
